// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC output conversion blocks.
//   bcd_digit_t        : one packed BCD digit
//   bcd_state_e        : state of the sequential binary-to-BCD converter
//   bcd_digits_needed  : decimal digits needed for the largest magnitude of a w-bit word
//                        (s=1: two's complement, largest magnitude 2**(w-1); s=0: 2**w-1)
package cordic_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    BCD_IDLE,
    BCD_CONV,
    BCD_DONE
  } bcd_state_e;

  function automatic int bcd_digits_needed(int w, bit s);
    longint unsigned v;
    int              n;
    v = s ? (64'd1 << (w - 1)) : ((64'd1 << w) - 64'd1);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 64'd10) begin
        v = v / 64'd10;
        n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/cordic_bcd_conv_add3.sv
// Double-dabble digit adjust: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
//   i_digit : digit before the shift
//   o_digit : adjusted digit
module bcd_add3
  import cordic_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/cordic_bcd_conv.sv
// Sequential binary to sign+magnitude BCD converter for CORDIC result words,
// with a leading-zero blank mask for the 7-segment scan driver.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : input word handshake, in_data is the word
//   out_valid/out_ready  : result handshake
//   out_neg              : result sign (always 0 when SIGNED=0)
//   out_bcd              : BCD magnitude, digit k at [4k+3:4k], k=0 is the LSD
//   out_blank            : bit k set when digit k is a leading zero (bit 0 never set)
//   dbg_state            : current converter state
//
// Handshake: a transfer happens on a posedge where valid and ready are both 1.
// in_ready and out_valid are registered state decodes; neither depends
// combinationally on the other side's signal. Valid, once raised, holds with
// its data stable until the transfer.
module cordic_bcd_conv
  import cordic_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_neg,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic [DIGITS-1:0]   out_blank,
  output bcd_state_e          dbg_state
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SH_W  = BCD_W + IN_W;
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  // DIGITS must cover the full unsigned range of the word even when SIGNED=1.
  if (DIGITS < bcd_digits_needed(IN_W, 1'b0)) begin : g_digits_check
    $error("cordic_bcd_conv: DIGITS too small for IN_W");
  end
  if (IN_W < 2) begin : g_width_check
    $error("cordic_bcd_conv: IN_W must be at least 2");
  end

  bcd_state_e         r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_out_neg;
  logic               r_neg;
  logic [BCD_W-1:0]   r_out_bcd;
  logic [DIGITS-1:0]  r_out_blank;
  logic [CNT_W-1:0]   r_cnt;
  // {bcd accumulator, magnitude} shifted together, one bit per cycle
  logic [SH_W-1:0]    r_sh;

  logic               w_neg;
  logic [IN_W-1:0]    w_mag_in;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [SH_W-1:0]    w_sh_next;
  logic [BCD_W-1:0]   w_bcd_next;
  logic [DIGITS-1:0]  w_blank_next;
  logic               w_zero;

  assign w_neg = SIGNED & in_data[IN_W-1];
  // Unsigned IN_W-bit negate keeps -2**(IN_W-1) exact.
  assign w_mag_in = w_neg ? (~in_data + IN_W'(1)) : in_data;

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_sh[IN_W + 4*k +: 4]),
      .o_digit (w_bcd_adj[4*k +: 4])
    );
  end

  assign w_sh_next  = {w_bcd_adj, r_sh[IN_W-1:0]} << 1;
  assign w_bcd_next = w_sh_next[SH_W-1 -: BCD_W];

  // Scan from the MSD down: a digit is blank while everything above it,
  // itself included, is zero. The LSD always shows.
  always_comb begin
    w_blank_next = '0;
    w_zero       = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      w_zero = w_zero & (w_bcd_next[4*k +: 4] == 4'd0);
      if (k > 0) begin
        w_blank_next[k] = w_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BCD_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_neg   <= 1'b0;
      r_out_bcd   <= '0;
      r_out_blank <= BLANK_RST;
      r_neg       <= 1'b0;
      r_cnt       <= '0;
      r_sh        <= '0;
    end else begin
      case (r_state)
        BCD_IDLE: begin
          if (in_valid) begin
            r_neg      <= w_neg;
            r_sh       <= {{BCD_W{1'b0}}, w_mag_in};
            r_cnt      <= CNT_W'(IN_W - 1);
            r_in_ready <= 1'b0;
            r_state    <= BCD_CONV;
          end
        end
        BCD_CONV: begin
          r_sh  <= w_sh_next;
          r_cnt <= r_cnt - CNT_W'(1);
          // Last shift: publish the result in the same cycle DONE is entered.
          if (r_cnt == '0) begin
            r_out_bcd   <= w_bcd_next;
            r_out_neg   <= r_neg;
            r_out_blank <= w_blank_next;
            r_out_valid <= 1'b1;
            r_state     <= BCD_DONE;
          end
        end
        BCD_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= BCD_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= BCD_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_neg   = r_out_neg;
  assign out_bcd   = r_out_bcd;
  assign out_blank = r_out_blank;
  assign dbg_state = r_state;

endmodule
